// File: rtl/spi_bridge_pkg.sv
// Shared constants, packet field offsets and FSM encoding for the SPI-to-emesh bridge.
package spi_bridge_pkg;

   localparam int          CMD_RD_BIT    = 7;
   localparam logic [1:0]  DATAMODE_32   = 2'b10;

   localparam int          PKT_WRITE_LSB = 0;
   localparam int          PKT_DMODE_LSB = 1;
   localparam int          PKT_CTRL_LSB  = 3;
   localparam int          PKT_DST_LSB   = 8;
   localparam int          PKT_DATA_LSB  = 40;
   localparam int          PKT_SRC_LSB   = 72;

   localparam logic [31:0] RD_MISS_FILL  = 32'hFFFF_FFFF;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_WR_ISSUE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_RDATA,
      ST_DONE
   } state_e;

endpackage

// File: rtl/spi_bridge_sync.sv
// Brings sclk, ss and mosi into the clk domain and flags sclk/ss edges.
module spi_bridge_sync (
   input  logic clk,
   input  logic reset,
   input  logic sclk_i,
   input  logic ss_i,
   input  logic mosi_i,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic ss_fall_o,
   output logic ss_rise_o,
   output logic ss_o,
   output logic mosi_o
);

   // [1] is the synchronized level, [2] its previous value for edge detection
   logic [2:0] sclk_q;
   logic [2:0] ss_q;
   logic [1:0] mosi_q;

   // ss resets high so leaving reset never looks like a slave-select assertion
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_q <= 3'b000;
         ss_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk_i};
         ss_q   <= {ss_q[1:0], ss_i};
         mosi_q <= {mosi_q[0], mosi_i};
      end
   end

   assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
   assign ss_fall_o   = ~ss_q[1] & ss_q[2];
   assign ss_rise_o   = ss_q[1] & ~ss_q[2];
   assign ss_o        = ss_q[1];
   assign mosi_o      = mosi_q[1];

endmodule

// File: rtl/spi_emesh_bridge.sv
// SPI slave frame decoder issuing emesh write/read packets and returning read data on miso.
module spi_emesh_bridge #(
   parameter int          AW      = 32,
   parameter int          PW      = 104,
   parameter logic [31:0] SRCADDR = 32'h0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sclk,
   input  logic          mosi,
   input  logic          ss,
   output logic          miso,
   output logic          access_out,
   output logic [PW-1:0] packet_out,
   input  logic          wait_in,
   input  logic          access_in,
   input  logic [PW-1:0] packet_in,
   output logic          wait_out,
   output logic          err_pulse
);

   import spi_bridge_pkg::*;

   logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_lvl, mosi_s;

   spi_bridge_sync u_sync (
      .clk        (clk),
      .reset      (reset),
      .sclk_i     (sclk),
      .ss_i       (ss),
      .mosi_i     (mosi),
      .sclk_rise_o(sclk_rise),
      .sclk_fall_o(sclk_fall),
      .ss_fall_o  (ss_fall),
      .ss_rise_o  (ss_rise),
      .ss_o       (ss_lvl),
      .mosi_o     (mosi_s)
   );

   state_e          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [31:0]     rx_q, rx_d;
   logic [31:0]     tx_q, tx_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            is_rd_q, is_rd_d;
   logic            miso_q, miso_d;
   logic            access_q, access_d;
   logic [PW-1:0]   pkt_q, pkt_d;
   logic            resp_q, resp_d;
   logic            ign_q, ign_d;
   logic            err_q, err_d;

   logic [31:0]     sh;
   logic            byte_end, word_end, xfer, in_rd_window;
   logic            unused_pkt_bits;

   assign unused_pkt_bits = ^{packet_in[PW-1:PKT_DATA_LSB+32], packet_in[PKT_DATA_LSB-1:0]};

   function automatic logic [PW-1:0] pack_pkt(input logic wr, input logic [AW-1:0] a,
                                              input logic [31:0] d);
      logic [PW-1:0] p;
      p = '0;
      p[PKT_WRITE_LSB]       = wr;
      p[PKT_DMODE_LSB +: 2]  = DATAMODE_32;
      p[PKT_DST_LSB +: AW]   = a;
      if (wr) p[PKT_DATA_LSB +: 32] = d;
      else    p[PKT_SRC_LSB +: 32]  = SRCADDR;
      return p;
   endfunction

   assign sh           = {rx_q[30:0], mosi_s};
   assign byte_end     = sclk_rise && (bit_cnt_q == 3'd7);
   assign word_end     = byte_end && (byte_cnt_q == 2'd3);
   assign xfer         = access_q && !wait_in;
   assign in_rd_window = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      addr_d     = addr_q;
      is_rd_d    = is_rd_q;
      miso_d     = miso_q;
      access_d   = access_q;
      pkt_d      = pkt_q;
      resp_d     = resp_q;
      ign_d      = ign_q;
      err_d      = 1'b0;

      if (access_in) begin
         if (in_rd_window && !resp_q) begin
            tx_d   = packet_in[PKT_DATA_LSB +: 32];
            resp_d = 1'b1;
         end else if (!in_rd_window) begin
            err_d = 1'b1;
         end
      end

      // a frame started while a packet was stuck in an ISSUE state is reported when it ends
      if (ss_rise && ign_q) begin
         err_d = 1'b1;
         ign_d = 1'b0;
      end

      if (sclk_rise && (state_q inside {ST_CMD, ST_ADDR, ST_WDATA, ST_RD_WAIT, ST_RDATA})) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) byte_cnt_d = byte_cnt_q + 2'd1;
         if (state_q inside {ST_CMD, ST_ADDR, ST_WDATA}) rx_d = sh;
      end

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d    = ST_CMD;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 2'd0;
               rx_d       = '0;
               resp_d     = 1'b0;
            end
         end
         ST_CMD: begin
            if (ss_lvl) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (byte_end) begin
               is_rd_d    = sh[CMD_RD_BIT];
               byte_cnt_d = 2'd0;
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (ss_lvl) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (word_end) begin
               addr_d = sh;
               if (is_rd_q) begin
                  state_d  = ST_RD_ISSUE;
                  access_d = 1'b1;
                  pkt_d    = pack_pkt(1'b0, sh, 32'h0);
               end else begin
                  state_d = ST_WDATA;
               end
            end
         end
         ST_WDATA: begin
            if (ss_lvl) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (word_end) begin
               state_d  = ST_WR_ISSUE;
               access_d = 1'b1;
               pkt_d    = pack_pkt(1'b1, addr_q, sh);
            end
         end
         ST_WR_ISSUE: begin
            if (ss_fall) ign_d = 1'b1;
            if (xfer) begin
               access_d = 1'b0;
               state_d  = ST_DONE;
            end
         end
         ST_RD_ISSUE: begin
            if (ss_fall) ign_d = 1'b1;
            if (xfer) begin
               access_d = 1'b0;
               state_d  = ign_d ? ST_DONE : ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (ss_lvl) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (byte_end) begin
               state_d    = ST_RDATA;
               byte_cnt_d = 2'd0;
               if (!resp_d) begin
                  tx_d  = RD_MISS_FILL;
                  err_d = 1'b1;
               end
            end
         end
         ST_RDATA: begin
            if (ss_lvl) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
               miso_d  = 1'b1;
            end else begin
               if (sclk_fall) begin
                  miso_d = tx_q[31];
                  tx_d   = {tx_q[30:0], 1'b1};
               end
               if (word_end) begin
                  state_d = ST_DONE;
                  miso_d  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (ss_lvl) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         addr_q     <= '0;
         is_rd_q    <= 1'b0;
         miso_q     <= 1'b1;
         access_q   <= 1'b0;
         pkt_q      <= '0;
         resp_q     <= 1'b0;
         ign_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         addr_q     <= addr_d;
         is_rd_q    <= is_rd_d;
         miso_q     <= miso_d;
         access_q   <= access_d;
         pkt_q      <= pkt_d;
         resp_q     <= resp_d;
         ign_q      <= ign_d;
         err_q      <= err_d;
      end
   end

   assign miso       = miso_q;
   assign access_out = access_q;
   assign packet_out = pkt_q;
   assign wait_out   = 1'b0;
   assign err_pulse  = err_q;

endmodule

// File: tb/tb_spi_emesh_bridge.sv
// Scoreboard bench: an SPI host drives frames, a core model responds, monitors check packets, miso and errors.
module tb_spi_emesh_bridge;

   localparam int          PW  = 104;
   localparam logic [31:0] SRC = 32'h5A5A_0F0F;

   logic          clk, reset, sclk, mosi, ss, miso;
   logic          access_out, wait_in, access_in, wait_out, err_pulse;
   logic [PW-1:0] packet_out, packet_in;

   spi_emesh_bridge #(.AW(32), .PW(PW), .SRCADDR(SRC)) dut (
      .clk       (clk),
      .reset     (reset),
      .sclk      (sclk),
      .mosi      (mosi),
      .ss        (ss),
      .miso      (miso),
      .access_out(access_out),
      .packet_out(packet_out),
      .wait_in   (wait_in),
      .access_in (access_in),
      .packet_in (packet_in),
      .wait_out  (wait_out),
      .err_pulse (err_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int err_cnt     = 0;
   int xfer_cnt    = 0;
   int hold_cycles = 0;
   int bp_fixed    = -1;
   int bp_n;
   int rsp_delay   = 4;
   bit rsp_en      = 1'b0;
   bit rsp_go      = 1'b0;
   logic [31:0] rsp_data;

   logic [PW-1:0] exp_pkt_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected emesh packet straight from the field layout
   function automatic logic [PW-1:0] model_pkt(input bit wr, input logic [31:0] a, input logic [31:0] d);
      if (wr) return {32'h0, d, a, 5'b0, 2'b10, 1'b1};
      else    return {SRC, 32'h0, a, 5'b0, 2'b10, 1'b0};
   endfunction

   always @(negedge clk) if (!reset && err_pulse) err_cnt++;

   // Packet monitor: every cycle access_out is up, the packet must match the head of the queue
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset && access_out) begin
            if (exp_pkt_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pkt: got %0h expected none", packet_out);
            end else begin
               check("packet", packet_out, exp_pkt_q[0]);
               check("wait_out", wait_out, 1'b0);
               if (wait_in) hold_cycles++;
               else begin
                  xfer_cnt++;
                  if (!exp_pkt_q[0][0] && rsp_en) rsp_go = 1'b1;
                  void'(exp_pkt_q.pop_front());
               end
            end
         end
      end
   end

   // Core backpressure: fixed length for directed tests, otherwise random
   initial begin
      wait_in = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && access_out) begin
            bp_n = (bp_fixed >= 0) ? bp_fixed : int'($urandom_range(0, 4));
            if (bp_n > 0) begin
               wait_in = 1'b1;
               repeat (bp_n) @(negedge clk);
               wait_in = 1'b0;
            end
            for (int k = 0; k < 50 && access_out; k++) @(negedge clk);
         end
      end
   end

   // Core read responder
   initial begin
      access_in = 1'b0;
      packet_in = '0;
      forever begin
         @(negedge clk);
         if (rsp_go) begin
            rsp_go = 1'b0;
            repeat (rsp_delay) @(negedge clk);
            packet_in = {32'($urandom), rsp_data, 32'($urandom), 8'($urandom)};
            access_in = 1'b1;
            @(negedge clk);
            access_in = 1'b0;
         end
      end
   end

   // SPI mode-0 host; stop_at truncates the frame to model an abort
   task automatic spi_xfer(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                           input int stop_at, output logic [31:0] rd_word);
      logic [79:0] bits;
      int nb;
      if (rd) begin
         bits = {1'b1, 7'($urandom), addr, 8'($urandom), 32'($urandom)};
         nb   = 80;
      end else begin
         bits = {1'b0, 7'($urandom), addr, wd, 8'h00};
         nb   = 72;
      end
      if (stop_at < nb) nb = stop_at;
      rd_word = '0;
      ss = 1'b0;
      #200;
      for (int i = 0; i < nb; i++) begin
         mosi = bits[79-i];
         #80;
         if (rd && i >= 48) rd_word = {rd_word[30:0], miso};
         sclk = 1'b1;
         #80;
         sclk = 1'b0;
      end
      #200;
      ss = 1'b1;
      #400;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && exp_pkt_q.size() != 0; k++) @(negedge clk);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      int e0, x0;
      logic [31:0] unused_rd;
      e0 = err_cnt;
      x0 = xfer_cnt;
      exp_pkt_q.push_back(model_pkt(1'b1, addr, data));
      spi_xfer(1'b0, addr, data, 1000, unused_rd);
      drain();
      check("wr_xfers", xfer_cnt - x0, 1);
      check("wr_err", err_cnt - e0, 0);
      check("miso_idle", miso, 1'b1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int dly, input bit miss);
      int e0, x0;
      logic [31:0] got;
      e0 = err_cnt;
      x0 = xfer_cnt;
      rsp_en    = !miss;
      rsp_delay = dly;
      rsp_data  = data;
      exp_pkt_q.push_back(model_pkt(1'b0, addr, 32'h0));
      spi_xfer(1'b1, addr, 32'h0, 1000, got);
      drain();
      check("rd_data", got, miss ? 32'hFFFF_FFFF : data);
      check("rd_xfers", xfer_cnt - x0, 1);
      check("rd_err", err_cnt - e0, miss ? 1 : 0);
      check("miso_idle", miso, 1'b1);
      rsp_en = 1'b0;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, x0, h0;
      logic [31:0] unused_rd;
      reset = 1'b1;
      ss    = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_access", access_out, 1'b0);
      check("rst_packet", packet_out, '0);
      check("rst_miso", miso, 1'b1);
      check("rst_err", err_pulse, 1'b0);
      check("rst_wait_out", wait_out, 1'b0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      do_write(32'h8000_1234, 32'hDEAD_BEEF);

      bp_fixed = 10;
      h0 = hold_cycles;
      do_write(32'h8000_1234, 32'hDEAD_BEEF);
      check("bp_hold_cycles", hold_cycles - h0, 10);
      bp_fixed = -1;

      do_read(32'h0000_0040, 32'hCAFE_0001, 4, 1'b0);
      do_read(32'h0000_0044, 32'h1234_5678, 4, 1'b1);

      e0 = err_cnt;
      x0 = xfer_cnt;
      spi_xfer(1'b0, 32'h1357_9BDF, 32'h0BAD_F00D, 20, unused_rd);
      repeat (20) @(negedge clk);
      check("abort_xfers", xfer_cnt - x0, 0);
      check("abort_err", err_cnt - e0, 1);
      check("abort_miso", miso, 1'b1);
      do_write(32'h2468_ACE0, 32'h0F1E_2D3C);

      e0 = err_cnt;
      @(negedge clk);
      packet_in = {PW{1'b1}};
      access_in = 1'b1;
      @(negedge clk);
      access_in = 1'b0;
      repeat (5) @(negedge clk);
      check("unexp_rsp_err", err_cnt - e0, 1);
      check("unexp_rsp_miso", miso, 1'b1);
      check("unexp_rsp_access", access_out, 1'b0);

      for (int t = 0; t < 16; t++) begin
         if ($urandom_range(0, 1) == 1)
            do_write($urandom, $urandom);
         else
            do_read($urandom, $urandom, int'($urandom_range(2, 60)), $urandom_range(0, 3) == 0);
      end

      check("queue_empty", exp_pkt_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_emesh_bridge.md
Name: spi_emesh_bridge

Overview:
- SPI slave-side transaction decoder that turns SPI frames into emesh write and read packets toward the core.
- Reverses the spi master's direction of traffic: an external SPI host drives transactions into the core fabric.
- Read responses returning from the core on the emesh input are serialized back out on miso.
- Sits beside the spi master/slave pair; its emesh ports feed the same mux.

Parameters:
- AW, 32, address width; fixed at 32 for the 4-byte address phase.
- PW, 104, emesh packet width.
- SRCADDR, 32'h0, srcaddr stamped into outgoing read packets.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous active-high reset
- sclk  input  1  SPI clock, asynchronous to clk
- mosi  input  1  SPI data in
- ss  input  1  slave select, active low
- miso  output  1  SPI data out
- access_out  output  1  packet valid to core
- packet_out  output  PW  packet to core
- wait_in  input  1  pushback from core
- access_in  input  1  read response from core
- packet_in  input  PW  response packet; data in [71:40]
- wait_out  output  1  pushback to core; tied 0
- err_pulse  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset: all outputs 0 except miso=1. FSM to IDLE; counters and shift registers cleared.
- Input sync: sclk, ss and mosi each pass through a 2-flop synchronizer; rise/fall edges are detected on synced sclk.
- Required clock ratio: clk >= 4x sclk.
- SPI mode 0, MSB first. Sample mosi on sclk rise; update miso on sclk fall.
- Frame format: CMD byte (bit7=1 read, 0 write; bits[6:0] ignored), then ADDR 4 bytes MSB first.
  - Write: 4 data bytes follow the address.
  - Read: 1 dummy byte, then 4 data bytes shifted out on miso.
- Counters: 3-bit bit counter, 2-bit byte counter; both wrap naturally.
- FSM states: IDLE, CMD, ADDR, WDATA, WR_ISSUE, RD_ISSUE, RD_WAIT, RDATA, DONE.
  - IDLE -> CMD on ss falling.
  - CMD -> ADDR after 8 bits.
  - ADDR -> WDATA (write) or RD_ISSUE (read) after 32 bits.
  - WDATA -> WR_ISSUE after 32 bits.
  - WR_ISSUE -> DONE once the packet is accepted.
  - RD_ISSUE -> RD_WAIT once the packet is accepted.
  - RD_WAIT -> RDATA at the dummy-byte end.
  - RDATA -> DONE after 32 bits.
  - DONE -> IDLE on ss rising.
- Packet format:
  - packet_out[0]=write, [2:1]=2'b10 (32-bit datamode), [7:3]=0, [39:8]=dstaddr.
  - Write: [71:40]=data, [103:72]=0.
  - Read: [71:40]=0, [103:72]=SRCADDR.
- Handshake: access_out rises the cycle after the last bit is sampled. packet_out is held stable until a cycle with access_out & !wait_in (transfer); access_out drops the next cycle.
- Response capture: access_in is captured only in RD_ISSUE or RD_WAIT, first beat only; [71:40] goes into the tx shift register.
  - access_in in any other state is dropped and raises err_pulse.
- Missing response: if no response has arrived by the end of the dummy byte, RDATA shifts 32'hFFFFFFFF and err_pulse fires.
- miso: 1 in all states other than RDATA. Bit 31 is driven on the last dummy-byte fall, i.e. ready before the first RDATA rise.
- ss rising mid-frame (before DONE): FSM goes to IDLE, partial data is discarded, err_pulse fires.
  - Exception: a packet already asserted on access_out is held until transferred. The FSM stays in an ISSUE state until then, ignoring the SPI side.
- ss falling while still in an ISSUE state: frame is ignored (bits dropped); err_pulse fires once ss later rises.
- Extra sclk edges in DONE are ignored.
- reset mid-operation: everything is cleared at once, including a pending access_out.

Decomposition:
- Package spi_bridge_pkg holds:
  - opcode bit position;
  - datamode constant 2'b10;
  - packet field offsets (write bit, datamode, ctrlmode, dstaddr, data, srcaddr);
  - FSM state enum;
  - read-miss fill value 32'hFFFFFFFF.
- Sub-module spi_bridge_sync: 2-flop synchronizers plus sclk rise/fall and ss fall/rise edge detect.
- Main block holds the FSM, shift registers and emesh packer.

Test Plan:
- Write: frame 8'h00, addr 32'h8000_1234, data 32'hDEADBEEF, wait_in=0 -> one access_out pulse; packet_out[0]=1, [39:8]=32'h8000_1234, [71:40]=32'hDEADBEEF.
- Write with backpressure: same frame, wait_in held high 10 cycles -> access_out and packet_out stable all 10 cycles; single transfer after wait_in falls.
- Read: frame 8'h80, addr 32'h0000_0040; core returns data 32'hCAFE0001 4 clk after the read transfer -> read packet srcaddr=SRCADDR; miso shifts 32'hCAFE0001 MSB first after the dummy byte.
- Read miss: no access_in -> miso shifts 32'hFFFFFFFF; exactly one err_pulse.
- Abort: ss deasserted after 12 address bits -> no access_out; FSM in IDLE; one err_pulse; next full write frame completes correctly.
- Unexpected response: access_in in IDLE -> dropped; err_pulse=1 for one cycle; no miso change.
